// File: rtl/ptp_ts_capture_fifo_if.sv
// ptp_ts_capture_fifo_if: timestamp FIFO read port (head entry, occupancy, pop).
interface ptp_ts_capture_fifo_if #(
    parameter int AW = 2
) ();
    logic          ts_pop_i;
    logic          ts_valid_o;
    logic [79:0]   ts_std_o;
    logic [15:0]   ts_fns_o;
    logic [15:0]   ts_seq_o;
    logic [AW:0]   ts_count_o;
    modport master (
        input  ts_pop_i,
        output ts_valid_o, ts_std_o, ts_fns_o, ts_seq_o, ts_count_o
    );
    modport slave (
        output ts_pop_i,
        input  ts_valid_o, ts_std_o, ts_fns_o, ts_seq_o, ts_count_o
    );
endinterface

// File: rtl/ptp_ts_capture_fifo.sv
// ptp_ts_capture_fifo: XGMII pass-through with PTPv2 start-of-frame timestamp capture into a tagged FIFO.
module ptp_ts_capture_fifo #(
    parameter int          DW            = 64,
    parameter int          CW            = DW / 8,
    parameter int          DEPTH         = 4,
    parameter int          AW            = $clog2(DEPTH),
    parameter int          LANE4_OFS_NS  = 3,
    parameter logic [15:0] LANE4_OFS_FNS = 16'd13107
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst_n,
    input  logic                  clk_en_i,
    input  logic                  dis_ptpv2_i,
    input  logic [DW-1:0]         xgmii_d_i,
    input  logic [CW-1:0]         xgmii_c_i,
    output logic [DW-1:0]         xgmii_d_o,
    output logic [CW-1:0]         xgmii_c_o,
    input  logic [79:0]           rtc_std_i,
    input  logic [15:0]           rtc_fns_i,
    ptp_ts_capture_fifo_if.master ts_if,
    output logic [7:0]            ovf_cnt_o,
    output logic                  int_o
);
    localparam logic [0:0]  S_IDLE     = 1'b0;
    localparam logic [0:0]  S_IN_FRAME = 1'b1;
    localparam logic [32:0] NS_MAX     = 33'd1_000_000_000;
    localparam logic [AW:0] FULL       = (AW + 1)'(DEPTH);

    logic [DW-1:0]  r_d;
    logic [CW-1:0]  r_c;
    logic [0:0]     r_state;
    logic [15:0]    r_seq;
    logic           r_cap_v;
    logic [79:0]    r_cap_std;
    logic [15:0]    r_cap_fns;
    logic [15:0]    r_cap_seq;
    logic [111:0]   r_mem [DEPTH];
    logic [AW-1:0]  r_wp, r_rp;
    logic [AW:0]    r_count;
    logic [7:0]     r_ovf;
    logic           r_int;

    logic           w_sof0, w_sof4, w_sof, w_lane4, w_term, w_cap;
    logic           w_push, w_pop, w_full, w_wr, w_valid, w_wrap;
    logic [16:0]    w_fns_sum;
    logic [32:0]    w_ns_sum;
    logic [79:0]    w_cap_std;

    assign w_sof0 = xgmii_c_i[0] && xgmii_d_i[7:0] == 8'hFB;

    generate
        if (DW == 64) begin : g_lane4
            assign w_sof4 = xgmii_c_i[4] && xgmii_d_i[39:32] == 8'hFB;
        end else begin : g_no_lane4
            assign w_sof4 = 1'b0;
        end
    endgenerate

    assign w_sof   = w_sof0 || w_sof4;
    assign w_lane4 = w_sof4 && !w_sof0;
    assign w_cap   = clk_en_i && w_sof && !dis_ptpv2_i;

    always_comb begin
        w_term = 1'b0;
        for (int i = 0; i < CW; i++)
            w_term = w_term || (xgmii_c_i[i] && (xgmii_d_i[8*i +: 8] == 8'hFD || xgmii_d_i[8*i +: 8] == 8'hFE));
    end

    // A lane-4 start arrives 4 byte times after lane 0, so its RTC sample is pushed forward.
    assign w_fns_sum = {1'b0, rtc_fns_i} + {1'b0, LANE4_OFS_FNS};
    assign w_ns_sum  = {1'b0, rtc_std_i[31:0]} + 33'(LANE4_OFS_NS) + {32'd0, w_fns_sum[16]};
    assign w_wrap    = w_ns_sum >= NS_MAX;
    assign w_cap_std = w_lane4 ? {rtc_std_i[79:32] + 48'(w_wrap), w_wrap ? 32'(w_ns_sum - NS_MAX) : w_ns_sum[31:0]}
                               : rtc_std_i;

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_d       <= {CW{8'h07}};
            r_c       <= '1;
            r_state   <= S_IDLE;
            r_seq     <= '0;
            r_cap_v   <= 1'b0;
            r_cap_std <= '0;
            r_cap_fns <= '0;
            r_cap_seq <= '0;
        end else if (clk_en_i) begin
            r_d     <= xgmii_d_i;
            r_c     <= xgmii_c_i;
            r_state <= w_sof ? S_IN_FRAME : (w_term ? S_IDLE : r_state);
            r_cap_v <= w_cap;
            if (w_cap) begin
                r_seq     <= r_seq + 16'd1;
                r_cap_std <= w_cap_std;
                r_cap_fns <= w_lane4 ? w_fns_sum[15:0] : rtc_fns_i;
                r_cap_seq <= r_seq;
            end
        end
    end

    // Pop is not qualified by clk_en_i; a push while full only lands if a pop frees the slot.
    assign w_valid = |r_count;
    assign w_full  = r_count == FULL;
    assign w_push  = clk_en_i && r_cap_v;
    assign w_pop   = ts_if.ts_pop_i && w_valid;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge rx_clk) begin
        if (w_wr)
            r_mem[r_wp] <= {r_cap_std, r_cap_fns, r_cap_seq};
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= '0;
            r_int   <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + AW'(1);
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            r_count <= r_count + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
            if (w_push && w_full && !w_pop && r_ovf != 8'hFF)
                r_ovf <= r_ovf + 8'd1;
            r_int <= w_valid;
        end
    end

    assign xgmii_d_o        = r_d;
    assign xgmii_c_o        = r_c;
    assign ts_if.ts_valid_o = w_valid;
    assign ts_if.ts_count_o = r_count;
    assign {ts_if.ts_std_o, ts_if.ts_fns_o, ts_if.ts_seq_o} = w_valid ? r_mem[r_rp] : '0;
    assign ovf_cnt_o        = r_ovf;
    assign int_o            = r_int;
endmodule

// File: tb/tb_ptp_ts_capture_fifo.sv
// tb_ptp_ts_capture_fifo: directed stimulus with queue scoreboards for 64-bit and 32-bit instances.
module tb_ptp_ts_capture_fifo;
    localparam logic [63:0] IDLE64 = {8{8'h07}};
    localparam logic [31:0] IDLE32 = {4{8'h07}};
    localparam logic [63:0] SOF0   = 64'hD5555555555555FB;

    typedef struct packed {
        logic [79:0] std;
        logic [15:0] fns;
        logic [15:0] seq;
    } ts_t;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1, dis = 1'b0;
    logic [63:0] d64 = IDLE64, d64_o;
    logic [7:0]  c64 = 8'hFF, c64_o;
    logic [31:0] d32 = IDLE32, d32_o;
    logic [3:0]  c32 = 4'hF, c32_o;
    logic [79:0] rtc_std = '0;
    logic [15:0] rtc_fns = '0;
    logic [7:0]  ovf64, ovf32;
    logic        int64, int32;
    int          checks = 0, errors = 0;
    ts_t         q64[$], q32[$];

    ptp_ts_capture_fifo_if #(.AW(2)) if64 ();
    ptp_ts_capture_fifo_if #(.AW(2)) if32 ();

    always #5 clk = ~clk;

    ptp_ts_capture_fifo #(.DW(64)) u64 (
        .rx_clk(clk), .rx_rst_n(rst_n), .clk_en_i(en), .dis_ptpv2_i(dis),
        .xgmii_d_i(d64), .xgmii_c_i(c64), .xgmii_d_o(d64_o), .xgmii_c_o(c64_o),
        .rtc_std_i(rtc_std), .rtc_fns_i(rtc_fns), .ts_if(if64.master),
        .ovf_cnt_o(ovf64), .int_o(int64)
    );

    ptp_ts_capture_fifo #(.DW(32)) u32 (
        .rx_clk(clk), .rx_rst_n(rst_n), .clk_en_i(en), .dis_ptpv2_i(dis),
        .xgmii_d_i(d32), .xgmii_c_i(c32), .xgmii_d_o(d32_o), .xgmii_c_o(c32_o),
        .rtc_std_i(rtc_std), .rtc_fns_i(rtc_fns), .ts_if(if32.master),
        .ovf_cnt_o(ovf32), .int_o(int32)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ts_t mk(input logic [47:0] s, input logic [31:0] ns, input logic [15:0] f, input logic [15:0] q);
        return {s, ns, f, q};
    endfunction

    // Scoreboard monitors: every accepted pop is checked against the oldest expected entry.
    always @(negedge clk) begin : mon64
        ts_t e;
        if (rst_n && if64.ts_pop_i) begin
            if (if64.ts_valid_o && q64.size() != 0) begin
                e = q64.pop_front();
                chk("sb64_entry", 128'({if64.ts_std_o, if64.ts_fns_o, if64.ts_seq_o}), 128'(e));
            end else if (if64.ts_valid_o || q64.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL sb64_sync: valid=%0b expected_entries=%0d", if64.ts_valid_o, q64.size());
            end
        end
    end

    always @(negedge clk) begin : mon32
        ts_t e;
        if (rst_n && if32.ts_pop_i) begin
            if (if32.ts_valid_o && q32.size() != 0) begin
                e = q32.pop_front();
                chk("sb32_entry", 128'({if32.ts_std_o, if32.ts_fns_o, if32.ts_seq_o}), 128'(e));
            end else if (if32.ts_valid_o || q32.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL sb32_sync: valid=%0b expected_entries=%0d", if32.ts_valid_o, q32.size());
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic w64(input logic [63:0] d, input logic [7:0] c);
        d64 = d;
        c64 = c;
        tick();
        d64 = IDLE64;
        c64 = 8'hFF;
    endtask

    task automatic pop64();
        if64.ts_pop_i = 1'b1;
        tick();
        if64.ts_pop_i = 1'b0;
    endtask

    task automatic pop32();
        if32.ts_pop_i = 1'b1;
        tick();
        if32.ts_pop_i = 1'b0;
    endtask

    initial begin
        if64.ts_pop_i = 1'b0;
        if32.ts_pop_i = 1'b0;
        #12;
        chk("rst_d_o", 128'(d64_o), 128'(IDLE64));
        chk("rst_c_o", 128'(c64_o), 128'(8'hFF));
        chk("rst_valid", 128'(if64.ts_valid_o), 128'(0));
        chk("rst_count", 128'(if64.ts_count_o), 128'(0));
        chk("rst_ovf", 128'(ovf64), 128'(0));
        chk("rst_int", 128'(int64), 128'(0));
        chk("rst_d32_o", 128'(d32_o), 128'(IDLE32));
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Lane-0 start: stored unmodified, 1-cycle pass-through, 2-cycle capture latency.
        rtc_std = {48'd5, 32'd100};
        rtc_fns = 16'd0;
        q64.push_back(mk(48'd5, 32'd100, 16'd0, 16'd0));
        w64(SOF0, 8'h01);
        chk("pass_d", 128'(d64_o), 128'(SOF0));
        chk("pass_c", 128'(c64_o), 128'(8'h01));
        chk("valid_lat1", 128'(if64.ts_valid_o), 128'(0));
        tick();
        chk("valid_lat2", 128'(if64.ts_valid_o), 128'(1));
        chk("count_one", 128'(if64.ts_count_o), 128'(1));
        chk("int_lag", 128'(int64), 128'(0));
        tick();
        chk("int_on", 128'(int64), 128'(1));
        pop64();

        // Lane-4 start with fns carry and ns rollover; lane 0 wins a double start; lane 2 ignored.
        rtc_std = {48'd7, 32'd999_999_997};
        rtc_fns = 16'hE000;
        q64.push_back(mk(48'd8, 32'd1, 16'h1333, 16'd1));
        w64(64'hD55555FB07070707, 8'h1F);
        rtc_std = {48'd9, 32'd10};
        rtc_fns = 16'd5;
        q64.push_back(mk(48'd9, 32'd10, 16'd5, 16'd2));
        w64(64'hD55555FBD55555FB, 8'h11);
        w64(64'h0707070707FB0707, 8'hFF);
        w64(64'h07070707070707FD, 8'hFF);
        tick(3);
        chk("count_two", 128'(if64.ts_count_o), 128'(2));
        pop64();
        pop64();

        // Six starts into a 4-deep FIFO: two dropped, seq still advances.
        rtc_fns = 16'd0;
        for (int i = 0; i < 6; i++) begin
            rtc_std = {48'(20 + i), 32'(i)};
            if (i < 4)
                q64.push_back(mk(48'(20 + i), 32'(i), 16'd0, 16'(3 + i)));
            w64(SOF0, 8'h01);
        end
        tick(3);
        chk("full_count", 128'(if64.ts_count_o), 128'(4));
        chk("full_ovf", 128'(ovf64), 128'(2));
        chk("full_int", 128'(int64), 128'(1));

        // Push and pop in the same cycle while full.
        rtc_std = {48'd40, 32'd0};
        q64.push_back(mk(48'd40, 32'd0, 16'd0, 16'd9));
        w64(SOF0, 8'h01);
        pop64();
        chk("pushpop_count", 128'(if64.ts_count_o), 128'(4));
        chk("pushpop_ovf", 128'(ovf64), 128'(2));
        repeat (4) pop64();
        chk("drain_count", 128'(if64.ts_count_o), 128'(0));
        chk("drain_int_lag", 128'(int64), 128'(1));
        tick();
        chk("drain_int_off", 128'(int64), 128'(0));
        pop64();
        chk("empty_pop", 128'(if64.ts_count_o), 128'(0));

        // Disabled capture holds seq; next start after release carries the held value.
        dis = 1'b1;
        rtc_std = {48'd50, 32'd0};
        w64(SOF0, 8'h01);
        tick(3);
        chk("dis_count", 128'(if64.ts_count_o), 128'(0));
        dis = 1'b0;
        rtc_std = {48'd60, 32'd0};
        q64.push_back(mk(48'd60, 32'd0, 16'd0, 16'd10));
        w64(SOF0, 8'h01);
        tick();
        chk("dis_release", 128'(if64.ts_count_o), 128'(1));
        pop64();

        // 32-bit instance: lane-2 start ignored, lane-0 start captured.
        d32 = 32'h55FB0707;
        c32 = 4'h7;
        tick();
        chk("pass32_d", 128'(d32_o), 128'(32'h55FB0707));
        d32 = IDLE32;
        c32 = 4'hF;
        tick(3);
        chk("l32_lane2", 128'(if32.ts_count_o), 128'(0));
        rtc_std = {48'd70, 32'd5};
        rtc_fns = 16'd9;
        q32.push_back(mk(48'd70, 32'd5, 16'd9, 16'd0));
        d32 = 32'h555555FB;
        c32 = 4'h1;
        tick();
        d32 = IDLE32;
        c32 = 4'hF;
        tick();
        chk("l32_lane0", 128'(if32.ts_count_o), 128'(1));
        pop32();

        // Asynchronous reset with three entries queued.
        rtc_fns = 16'd0;
        for (int i = 0; i < 3; i++) begin
            rtc_std = {48'(80 + i), 32'd0};
            w64(SOF0, 8'h01);
        end
        tick(3);
        chk("pre_rst_count", 128'(if64.ts_count_o), 128'(3));
        d64 = 64'h1122334455667788;
        c64 = 8'h00;
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_count", 128'(if64.ts_count_o), 128'(0));
        chk("arst_valid", 128'(if64.ts_valid_o), 128'(0));
        chk("arst_int", 128'(int64), 128'(0));
        chk("arst_ovf", 128'(ovf64), 128'(0));
        chk("arst_c_o", 128'(c64_o), 128'(8'hFF));
        chk("arst_d_o", 128'(d64_o), 128'(IDLE64));
        d64 = IDLE64;
        c64 = 8'hFF;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Sequence counter restarts from zero after reset.
        rtc_std = {48'd90, 32'd0};
        q64.push_back(mk(48'd90, 32'd0, 16'd0, 16'd0));
        w64(SOF0, 8'h01);
        tick();
        pop64();
        tick();
        chk("q64_drained", 128'(q64.size()), 128'(0));
        chk("q32_drained", 128'(q32.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
